// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Multi-cycle command sequencer for a register-file/ALU processing unit.
// Each accepted command either writes an immediate straight into the
// register file (load) or reads two source registers, lets the ALU
// evaluate them and writes the ALU result back (ALU op). The sequencer
// owns every control input of the processing unit; the unit's read data
// (a, b) and ALU result feed back into it.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   clr           synchronous active-high reset
//   cmd_valid     command present
//   cmd_ready     command can be accepted (IDLE and not in reset)
//   cmd_load      1 = load immediate, 0 = ALU operation
//   cmd_rs1/rs2   source register addresses
//   cmd_rd        destination register address
//   cmd_alu_ctrl  ALU opcode (000 add .. 111 xor, 011 = div)
//   cmd_imm       immediate value for loads
//   readreg1/2    register file read addresses
//   writereg      register file write address
//   data          register file write data
//   regwrite      register file write enable (WRITE state only)
//   alu_ctrl      ALU opcode
//   a, b          register read data (combinational from readreg1/2)
//   result        ALU output (combinational from a, b, alu_ctrl)
//   done          one-cycle completion pulse
//   done_result   value written, or 0 on divide-by-zero
//   err           one-cycle divide-by-zero pulse, coincident with done
//   busy          state is not IDLE
//   op_count      saturating count of successful completions

module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [2:0]        cmd_alu_ctrl,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] readreg1,
  output logic [ADDR_W-1:0] readreg2,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] data,
  output logic              regwrite,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] result,
  output logic              done,
  output logic [DATA_W-1:0] done_result,
  output logic              err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                w_accept;
  logic                w_div0;
  logic                w_unused_a;

  // Latched command fields that are not already held in an output register
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_b_q;

  // Output registers
  logic [ADDR_W-1:0]   r_readreg1;
  logic [ADDR_W-1:0]   r_readreg2;
  logic [ADDR_W-1:0]   r_writereg;
  logic [DATA_W-1:0]   r_data;
  logic                r_regwrite;
  logic [2:0]          r_alu_ctrl;
  logic                r_done;
  logic [DATA_W-1:0]   r_done_result;
  logic                r_err;
  logic [CNT_W-1:0]    r_op_count;

  // Saturating increment for the completion counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign cmd_ready = (r_state == S_IDLE) & ~clr;
  assign w_accept  = cmd_valid & cmd_ready;

  // The divisor was captured from b during READ; the opcode is still on
  // alu_ctrl, so the zero check is made against stable registered values.
  assign w_div0 = (r_alu_ctrl == OP_DIV) && (r_b_q == '0);

  // Operand a goes straight from the register file into the ALU; the
  // sequencer itself never needs its value.
  assign w_unused_a = ^a;

  // ---------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = cmd_load ? S_WRITE : S_READ;
        end
      end
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Command latch and divisor capture (no reset needed: always written
  // before being read within a command)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd <= cmd_rd;
    end
    if (r_state == S_READ) begin
      r_b_q <= b;
    end
  end

  // ---------------------------------------------------------------------
  // Output registers. Values are loaded on the edge that enters the state
  // in which they are used, so they are stable for that whole cycle and
  // hold afterwards. Pulses (regwrite/done/err) default low each cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_readreg1    <= '0;
      r_readreg2    <= '0;
      r_writereg    <= '0;
      r_data        <= '0;
      r_regwrite    <= 1'b0;
      r_alu_ctrl    <= '0;
      r_done        <= 1'b0;
      r_done_result <= '0;
      r_err         <= 1'b0;
      r_op_count    <= '0;
    end else begin
      r_regwrite <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;

      if (w_accept) begin
        if (cmd_load) begin
          // Load goes straight to WRITE next cycle
          r_writereg    <= cmd_rd;
          r_data        <= cmd_imm;
          r_regwrite    <= 1'b1;
          r_done        <= 1'b1;
          r_done_result <= cmd_imm;
        end else begin
          // Addresses/opcode presented for READ and held through EXEC
          r_readreg1 <= cmd_rs1;
          r_readreg2 <= cmd_rs2;
          r_alu_ctrl <= cmd_alu_ctrl;
        end
      end

      if (r_state == S_EXEC) begin
        // ALU result captured here becomes the WRITE-cycle data
        r_writereg    <= r_rd;
        r_data        <= result;
        r_regwrite    <= ~w_div0;
        r_done        <= 1'b1;
        r_err         <= w_div0;
        r_done_result <= w_div0 ? '0 : result;
      end

      // Count at the close of a successful WRITE cycle
      if ((r_state == S_WRITE) && !r_err) begin
        r_op_count <= sat_inc(r_op_count);
      end
    end
  end

  assign readreg1    = r_readreg1;
  assign readreg2    = r_readreg2;
  assign writereg    = r_writereg;
  assign data        = r_data;
  assign regwrite    = r_regwrite;
  assign alu_ctrl    = r_alu_ctrl;
  assign done        = r_done;
  assign done_result = r_done_result;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE);
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_load;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [2:0]    cmd_alu_ctrl;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] readreg1, readreg2, writereg;
  logic [DW-1:0] data;
  logic          regwrite;
  logic [2:0]    alu_ctrl;
  logic [DW-1:0] a, b, result;
  logic          done;
  logic [DW-1:0] done_result;
  logic          err;
  logic          busy;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .cmd_alu_ctrl(cmd_alu_ctrl), .cmd_imm(cmd_imm),
    .readreg1(readreg1), .readreg2(readreg2), .writereg(writereg),
    .data(data), .regwrite(regwrite), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .result(result),
    .done(done), .done_result(done_result), .err(err), .busy(busy),
    .op_count(op_count)
  );

  // ALU behaviour from the opcode table, in plain arithmetic
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] x,
                                          input logic [DW-1:0] y,
                                          input logic [2:0] op);
    logic [DW-1:0] r;
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: r = (y == 0) ? '1 : x / y;
      3'd4: r = x & y;
      3'd5: r = ~x;
      3'd6: r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  // Processing unit stand-in: register file + combinational ALU
  logic          rf_clr;
  logic [DW-1:0] rf [0:31];
  assign a      = rf[readreg1];
  assign b      = rf[readreg2];
  assign result = alu_f(a, b, alu_ctrl);
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwrite) begin
      rf[writereg] <= data;
    end
  end

  // Reference model state: architectural registers and completion count
  logic [DW-1:0] mrf [0:31];
  int            mcount;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic ld, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [2:0] op, input logic [DW-1:0] imm);
    cmd_load = ld; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    cmd_alu_ctrl = op; cmd_imm = imm;
  endtask

  // Issue one command, check its WRITE cycle at the required latency
  // against the model, then commit it to the model.
  task automatic run_cmd(input logic ld, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [2:0] op, input logic [DW-1:0] imm,
                         input string tag, output logic [DW-1:0] got_res, output logic got_err);
    logic [DW-1:0] exp_v;
    logic          exp_e;
    int            lat;
    int            waited;
    if (ld) begin
      exp_v = imm; exp_e = 1'b0;
    end else begin
      exp_e = (op == 3'd3) && (mrf[rs2] == 0);
      exp_v = exp_e ? '0 : alu_f(mrf[rs1], mrf[rs2], op);
    end
    lat = ld ? 1 : 3;
    got_res = 'x; got_err = 'x;
    set_cmd(ld, rs1, rs2, rd, op, imm);
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      tick;
      waited++;
    end
    if (!cmd_ready) begin
      chk({tag, " ready_timeout"}, cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    tick;
    cmd_valid = 1'b0;
    chk({tag, " busy"}, busy, 1);
    for (int i = 1; i < lat; i++) begin
      chk({tag, " early_done"}, done, 0);
      tick;
    end
    got_res = done_result;
    got_err = err;
    chk({tag, " done"}, done, 1);
    chk({tag, " regwrite"}, regwrite, !exp_e);
    chk({tag, " writereg"}, writereg, rd);
    chk({tag, " err"}, err, exp_e);
    chk({tag, " done_result"}, done_result, exp_v);
    if (!exp_e) chk({tag, " data"}, data, exp_v);
    tick;
    chk({tag, " done_clear"}, done, 0);
    if (!exp_e) begin
      mrf[rd] = exp_v;
      if (mcount < 65535) mcount++;
    end
    chk({tag, " op_count"}, op_count, mcount);
    chk({tag, " rf_dest"}, rf[rd], mrf[rd]);
  endtask

  // Burst with cmd_valid held high throughout
  logic          bl_ld  [0:2];
  logic [AW-1:0] bl_rs1 [0:2];
  logic [AW-1:0] bl_rs2 [0:2];
  logic [AW-1:0] bl_rd  [0:2];
  logic [2:0]    bl_op  [0:2];
  logic [DW-1:0] bl_imm [0:2];
  logic [DW-1:0] bl_exp [0:2];
  int            acc_cyc [0:2];
  int            done_cyc [0:2];

  task automatic run_burst(input int n);
    int  idx;
    int  nd;
    logic acc;
    for (int k = 0; k < 3; k++) begin acc_cyc[k] = -100; done_cyc[k] = -100; end
    for (int k = 0; k < n; k++) begin
      bl_exp[k] = bl_ld[k] ? bl_imm[k] : alu_f(mrf[bl_rs1[k]], mrf[bl_rs2[k]], bl_op[k]);
      mrf[bl_rd[k]] = bl_exp[k];
      mcount++;
    end
    idx = 0; nd = 0;
    set_cmd(bl_ld[0], bl_rs1[0], bl_rs2[0], bl_rd[0], bl_op[0], bl_imm[0]);
    cmd_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      acc = cmd_valid & cmd_ready;
      if (acc) acc_cyc[idx] = c;
      tick;
      if (acc) begin
        idx++;
        if (idx < n) set_cmd(bl_ld[idx], bl_rs1[idx], bl_rs2[idx], bl_rd[idx], bl_op[idx], bl_imm[idx]);
        else cmd_valid = 1'b0;
      end
      if (done && nd < n) begin
        chk("burst done_result", done_result, bl_exp[nd]);
        done_cyc[nd] = c + 1;
        nd++;
      end
    end
    cmd_valid = 1'b0;
    chk("burst accepted", idx, n);
    chk("burst completed", nd, n);
  endtask

  typedef struct {
    logic          ld;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [2:0]    op;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_res;
    logic          exp_err;
  } vec_t;

  vec_t tbl [0:13];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] gres;
    logic          gerr;
    int            bad;

    tbl[0]  = '{1'b1, 5'd0, 5'd0, 5'd1,  3'd0, 32'd7,        32'd7,        1'b0};
    tbl[1]  = '{1'b1, 5'd0, 5'd0, 5'd2,  3'd0, 32'd5,        32'd5,        1'b0};
    tbl[2]  = '{1'b0, 5'd1, 5'd2, 5'd3,  3'd0, 32'd0,        32'd12,       1'b0};
    tbl[3]  = '{1'b0, 5'd2, 5'd1, 5'd4,  3'd1, 32'd0,        32'hFFFFFFFE, 1'b0};
    tbl[4]  = '{1'b1, 5'd0, 5'd0, 5'd5,  3'd0, 32'h00010000, 32'h00010000, 1'b0};
    tbl[5]  = '{1'b0, 5'd5, 5'd5, 5'd6,  3'd2, 32'd0,        32'd0,        1'b0};
    tbl[6]  = '{1'b1, 5'd0, 5'd0, 5'd7,  3'd0, 32'd0,        32'd0,        1'b0};
    tbl[7]  = '{1'b0, 5'd7, 5'd0, 5'd8,  3'd5, 32'd0,        32'hFFFFFFFF, 1'b0};
    tbl[8]  = '{1'b1, 5'd0, 5'd0, 5'd9,  3'd0, 32'h1234,     32'h1234,     1'b0};
    tbl[9]  = '{1'b0, 5'd1, 5'd7, 5'd9,  3'd3, 32'd0,        32'd0,        1'b1};
    tbl[10] = '{1'b0, 5'd1, 5'd2, 5'd10, 3'd3, 32'd0,        32'd1,        1'b0};
    tbl[11] = '{1'b0, 5'd1, 5'd2, 5'd11, 3'd4, 32'd0,        32'd5,        1'b0};
    tbl[12] = '{1'b0, 5'd1, 5'd2, 5'd12, 3'd6, 32'd0,        32'd7,        1'b0};
    tbl[13] = '{1'b0, 5'd1, 5'd2, 5'd13, 3'd7, 32'd0,        32'd2,        1'b0};

    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mcount = 0;
    clr = 1'b1; rf_clr = 1'b1; cmd_valid = 1'b0;
    set_cmd(1'b0, '0, '0, '0, 3'd0, '0);

    // Reset state
    repeat (3) tick;
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst regwrite", regwrite, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst op_count", op_count, 0);
    chk("rst readreg1", readreg1, 0);
    chk("rst writereg", writereg, 0);
    chk("rst data", data, 0);
    chk("rst done_result", done_result, 0);
    chk("rst alu_ctrl", alu_ctrl, 0);
    clr = 1'b0; rf_clr = 1'b0;
    #1;
    chk("post_rst cmd_ready", cmd_ready, 1);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_cmd(tbl[i].ld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].op, tbl[i].imm,
              $sformatf("vec%0d", i), gres, gerr);
      chk($sformatf("vec%0d table_result", i), gres, tbl[i].exp_res);
      chk($sformatf("vec%0d table_err", i), gerr, tbl[i].exp_err);
      if (i == 2) chk("op_count after add", op_count, 3);
      if (i == 9) begin
        chk("div0 op_count unchanged", op_count, 9);
        chk("div0 dest preserved", rf[9], 32'h1234);
      end
    end

    // Reset during EXEC aborts the command
    set_cmd(1'b0, 5'd1, 5'd2, 5'd20, 3'd0, '0);
    cmd_valid = 1'b1;
    tick;                       // accepted; READ
    cmd_valid = 1'b0;
    tick;                       // EXEC
    clr = 1'b1;
    tick;
    chk("abort busy", busy, 0);
    chk("abort regwrite", regwrite, 0);
    chk("abort done", done, 0);
    chk("abort op_count", op_count, 0);
    chk("abort data", data, 0);
    chk("abort readreg1", readreg1, 0);
    chk("abort readreg2", readreg2, 0);
    chk("abort alu_ctrl", alu_ctrl, 0);
    chk("abort done_result", done_result, 0);
    chk("abort cmd_ready_in_clr", cmd_ready, 0);
    clr = 1'b0;
    #1;
    chk("abort cmd_ready", cmd_ready, 1);
    mcount = 0;
    bad = 0;
    repeat (4) begin
      tick;
      if (regwrite || done) bad++;
    end
    chk("abort no_write_pulse", bad, 0);
    chk("abort rf20", rf[20], mrf[20]);

    // Three back-to-back ALU ops with cmd_valid held high
    bl_ld[0] = 0; bl_rs1[0] = 5'd1;  bl_rs2[0] = 5'd2;  bl_rd[0] = 5'd14; bl_op[0] = 3'd0; bl_imm[0] = '0;
    bl_ld[1] = 0; bl_rs1[1] = 5'd14; bl_rs2[1] = 5'd1;  bl_rd[1] = 5'd15; bl_op[1] = 3'd0; bl_imm[1] = '0;
    bl_ld[2] = 0; bl_rs1[2] = 5'd15; bl_rs2[2] = 5'd15; bl_rd[2] = 5'd16; bl_op[2] = 3'd0; bl_imm[2] = '0;
    run_burst(3);
    chk("b2b acc_gap01", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b acc_gap12", acc_cyc[2] - acc_cyc[1], 4);
    chk("b2b latency", done_cyc[0] - acc_cyc[0], 3);
    chk("b2b r15", rf[15], 32'd19);
    chk("b2b r16", rf[16], 32'd38);
    chk("b2b op_count", op_count, 3);

    // Two back-to-back loads
    bl_ld[0] = 1; bl_rs1[0] = '0; bl_rs2[0] = '0; bl_rd[0] = 5'd31; bl_op[0] = 3'd0; bl_imm[0] = 32'hDEADBEEF;
    bl_ld[1] = 1; bl_rs1[1] = '0; bl_rs2[1] = '0; bl_rd[1] = 5'd30; bl_op[1] = 3'd0; bl_imm[1] = 32'h0BADF00D;
    run_burst(2);
    chk("ld2 acc_gap", acc_cyc[1] - acc_cyc[0], 2);
    chk("ld2 done0", done_cyc[0] - acc_cyc[0], 1);
    chk("ld2 done1", done_cyc[1] - acc_cyc[0], 3);
    tick;
    chk("ld2 r31", rf[31], 32'hDEADBEEF);
    chk("ld2 r30", rf[30], 32'h0BADF00D);

    // Randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      logic          rld;
      logic [DW-1:0] rimm;
      rld  = ($urandom_range(0, 2) == 0);
      rimm = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      run_cmd(rld, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rimm,
              $sformatf("rnd%0d", i), gres, gerr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle command sequencer that drives the register-file/ALU processing unit on behalf of one upstream requester. For each accepted command it reads two source registers, lets the ALU evaluate, and writes the result back, or writes an immediate directly. It owns every control input of the processing unit: read addresses, write address, write data, `regwrite` and `alu_ctrl`. The unit's `a`, `b` and `result` outputs feed back into the sequencer.

## Interface
Parameters:
- `DATA_W`, 32: register and ALU data width.
- `ADDR_W`, 5: register address width.
- `CNT_W`, 16: completed-operation counter width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `clr`  in  1: reset, synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_load`  in  1: 1 = load immediate, 0 = ALU operation.
- `cmd_rs1`, `cmd_rs2`  in  ADDR_W: source register addresses.
- `cmd_rd`  in  ADDR_W: destination register address.
- `cmd_alu_ctrl`  in  3: ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 and, 101 not a, 110 or, 111 xor).
- `cmd_imm`  in  DATA_W: immediate value for loads.
- `readreg1`, `readreg2`  out  ADDR_W: register file read addresses.
- `writereg`  out  ADDR_W: register file write address.
- `data`  out  DATA_W: register file write data.
- `regwrite`  out  1: register file write enable.
- `alu_ctrl`  out  3: ALU opcode.
- `a`, `b`  in  DATA_W: register read data; combinational from `readreg1` and `readreg2`.
- `result`  in  DATA_W: ALU output; combinational from `a`, `b` and `alu_ctrl`.
- `done`  out  1: one-cycle completion pulse.
- `done_result`  out  DATA_W: value written, or 0 on error; valid while `done`=1.
- `err`  out  1: one-cycle pulse with `done` when a divide by zero is detected.
- `busy`  out  1: high whenever the state is not IDLE.
- `op_count`  out  CNT_W: number of successful completions.

## Operation
- States: IDLE, READ, EXEC, WRITE.
- `cmd_ready` = (state==IDLE) & ~`clr`.
- A command is accepted on a rising edge with `cmd_valid` & `cmd_ready`. On acceptance all `cmd_*` fields are latched; inputs are ignored in every other cycle.
- IDLE → READ on an accepted ALU command; IDLE → WRITE on an accepted load.
- READ:
  - `readreg1`/`readreg2` = latched rs1/rs2.
  - `alu_ctrl` = latched opcode.
  - `b` is captured into `b_q`.
  - Next state is EXEC.
- EXEC:
  - Addresses and opcode are held.
  - `result` is captured into `res_q`.
  - `div0` = (opcode==011) & (`b_q`==0) is registered.
  - Next state is WRITE.
- WRITE:
  - `writereg` = latched rd.
  - `data` = `res_q` for an ALU op, latched imm for a load.
  - `regwrite` = 1 unless `div0`.
  - `done` = 1, `err` = `div0`, `done_result` = `div0` ? 0 : `data`.
  - Next state is IDLE.
- `op_count` increments on each `done` with `err`=0 and saturates at all-ones.
- Outside WRITE: `regwrite`, `done` and `err` are 0. `readreg*`, `writereg`, `data`, `alu_ctrl` and `done_result` hold their last values.
- Arithmetic is performed by the ALU. The captured `result` is the low DATA_W bits, so mul truncates and add/sub wrap modulo 2^DATA_W.
- Writes to any `rd`, including 0, proceed normally.
- Commands are processed strictly one at a time. A READ always observes every earlier WRITE, so no hazard logic is needed.

## Timing
- Reset (`clr`=1 at an edge):
  - state → IDLE.
  - All outputs → 0 on the following cycle: addresses, `data`, `alu_ctrl`, `done_result`, `op_count`, `regwrite`, `done`, `err`, `busy`.
  - `cmd_ready` = 0 while `clr` is high and 1 from the first cycle after.
- Reset mid-operation aborts the command: no register write occurs, `done` is not produced, and `op_count` returns to 0.
- ALU command accepted at edge N: READ in cycle N+1, EXEC in cycle N+2, WRITE (`regwrite`, `done`) in cycle N+3. The register file commits at edge N+4, and `cmd_ready` is 1 in cycle N+4.
- Load accepted at edge N: WRITE in cycle N+1, `cmd_ready` in cycle N+2.
- Throughput: 1 ALU op per 4 cycles, 1 load per 2 cycles.
- `cmd_valid` held high continuously: a new command is accepted on the first IDLE edge.

## Test plan
- Reset, then load r1=7 and r2=5, then ALU add rd=r3: `regwrite`=1 with `writereg`=3, `data`=12, `done_result`=12 exactly 3 cycles after acceptance; `op_count`=3.
- sub r4 = r2−r1 with r1=7, r2=5: `data`=0xFFFFFFFE. mul of 0x10000×0x10000: `data`=0. not a with a=0: `data`=0xFFFFFFFF.
- div with r2=0: `regwrite` stays 0 in WRITE; `done`=1, `err`=1, `done_result`=0; `op_count` unchanged; destination register still holds its old value.
- `cmd_valid` held high across 3 back-to-back ALU commands: acceptances 4 cycles apart; `cmd_ready` low in READ/EXEC/WRITE; the second command's READ sees the first command's write.
- `clr` asserted in the EXEC cycle: next cycle all outputs 0, `busy`=0, no `regwrite` pulse, `cmd_ready`=1 one cycle after `clr` drops.
- Load `cmd_imm`=0xDEADBEEF to r31 immediately followed by a second load: `done` pulses in cycles N+1 and N+3.
